// File: rtl/hex_display_ctrl.sv
// Six-digit seven-segment sequencer: blank/message/number commands, sequential
// double-dabble binary-to-BCD conversion, leading-zero blanking and blinking.
module hex_display_ctrl #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_msg,
    input  logic [19:0] cmd_value,
    input  logic        cmd_lz_blank,
    input  logic        cmd_blink,
    output logic        busy,
    output logic [29:0] hex_codes
);

    localparam int CNT_W = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BLINK_DIV - 1);
    localparam logic [29:0]      ALL_BLANK = 30'h3FFFFFFF;
    localparam logic [19:0]      MAX_SHOWN = 20'd999999;
    localparam logic [4:0]       LAST_STEP = 5'd19;

    localparam logic [4:0] C_E   = 5'd14;
    localparam logic [4:0] C_R   = 5'd16;
    localparam logic [4:0] C_G   = 5'd17;
    localparam logic [4:0] C_O   = 5'd18;
    localparam logic [4:0] C_H   = 5'd19;
    localparam logic [4:0] C_I   = 5'd1;
    localparam logic [4:0] C_S   = 5'd5;
    localparam logic [4:0] C_C   = 5'd12;
    localparam logic [4:0] C_BIG = 5'd0;
    localparam logic [4:0] C_BL  = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_CONV,
        S_LOAD
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] disp_q, disp_d;
    logic        blink_flag_q, blink_flag_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic        phase_q, phase_d;
    logic [29:0] hex_q, hex_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic [19:0] bin_q, bin_d;
    logic [23:0] bcd_q, bcd_d;
    logic [4:0]  iter_q, iter_d;
    logic        lz_q, lz_d;
    logic        blink_pend_q, blink_pend_d;

    logic        accept;
    logic [23:0] bcd_adj;

    // Messages are left-justified starting at HEX5, unused digits blank.
    function automatic logic [29:0] msg_codes(input logic [1:0] sel);
        logic [29:0] codes;
        case (sel)
            2'd0:    codes = {C_H, C_I, C_BL, C_BL, C_BL, C_BL};
            2'd1:    codes = {C_G, C_O, C_BL, C_BL, C_BL, C_BL};
            2'd2:    codes = {C_E, C_R, C_R, C_BL, C_BL, C_BL};
            default: codes = {C_S, C_C, C_BIG, C_R, C_E, C_BL};
        endcase
        return codes;
    endfunction

    // HEX0 is never blanked so that a value of zero still shows a single 0.
    function automatic logic [29:0] bcd_to_codes(input logic [23:0] bcd,
                                                 input logic        lz);
        logic [29:0] codes;
        logic        leading;
        logic [3:0]  nib;
        codes   = ALL_BLANK;
        leading = lz;
        for (int i = 5; i >= 0; i--) begin
            nib = bcd[4*i +: 4];
            if (leading && (nib == 4'd0) && (i != 0)) begin
                codes[5*i +: 5] = C_BL;
            end else begin
                codes[5*i +: 5] = {1'b0, nib};
                leading         = 1'b0;
            end
        end
        return codes;
    endfunction

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 6; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    assign accept = cmd_valid & ready_q;

    always_comb begin
        state_d      = state_q;
        disp_d       = disp_q;
        blink_flag_d = blink_flag_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        iter_d       = iter_q;
        lz_d         = lz_q;
        blink_pend_d = blink_pend_q;

        if (blink_cnt_q == CNT_MAX) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
            phase_d     = phase_q;
        end

        case (state_q)
            S_IDLE, S_SHOW: begin
                if (accept) begin
                    blink_cnt_d = '0;
                    phase_d     = 1'b1;
                    case (cmd_op)
                        2'd1: begin
                            disp_d       = msg_codes(cmd_msg);
                            blink_flag_d = cmd_blink;
                            state_d      = S_SHOW;
                        end
                        2'd2: begin
                            bin_d        = (cmd_value > MAX_SHOWN) ? MAX_SHOWN : cmd_value;
                            lz_d         = cmd_lz_blank;
                            blink_pend_d = cmd_blink;
                            bcd_d        = '0;
                            iter_d       = '0;
                            state_d      = S_CONV;
                        end
                        default: begin
                            disp_d       = ALL_BLANK;
                            blink_flag_d = cmd_blink;
                            state_d      = S_SHOW;
                        end
                    endcase
                end
            end
            S_CONV: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                iter_d         = iter_q + 5'd1;
                if (iter_q == LAST_STEP) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                disp_d       = bcd_to_codes(bcd_q, lz_q);
                blink_flag_d = blink_pend_q;
                state_d      = S_SHOW;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE) || (state_d == S_SHOW);
        busy_d  = ~ready_d;
        // Built from next-state values so a phase toggle shows on its own edge.
        hex_d   = (!blink_flag_d || phase_d) ? disp_d : ALL_BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            disp_q       <= ALL_BLANK;
            blink_flag_q <= 1'b0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b1;
            hex_q        <= ALL_BLANK;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            bin_q        <= '0;
            bcd_q        <= '0;
            iter_q       <= '0;
            lz_q         <= 1'b0;
            blink_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            disp_q       <= disp_d;
            blink_flag_q <= blink_flag_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            hex_q        <= hex_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            iter_q       <= iter_d;
            lz_q         <= lz_d;
            blink_pend_q <= blink_pend_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign hex_codes = hex_q;

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Display sequencer for the six seven-segment digits of the reaction-timer board.
- Accepts blank, message and number commands from the game FSM.
- Converts binary reaction times to decimal with a sequential double-dabble.
- Drives six 5-bit character codes, one per downstream hex driver instance, with optional blinking and leading-zero blanking.

Parameters:
BLINK_DIV, 25000000, clock cycles per blink half-period (on phase or off phase); must be >= 2

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command strobe
cmd_ready  output  1  high when a command can be accepted
cmd_op  input  2  0 = blank, 1 = message, 2 = number, 3 = reserved (treated as blank)
cmd_msg  input  2  message select: 0 "HI", 1 "go", 2 "Err", 3 "SCOrE"
cmd_value  input  20  binary number for op 2
cmd_lz_blank  input  1  blank leading zeros (op 2 only)
cmd_blink  input  1  blink the displayed content
busy  output  1  high while a conversion is in progress
hex_codes  output  30  six character codes; [4:0] = HEX0 (rightmost) ... [29:25] = HEX5 (leftmost)

Behaviour:
- Character codes: 0-9 digits; E=14; r=16; g=17; o=18; H=19; I=1; S=5; C=12; O=0; blank=31.
- Reset (synchronous, applied on a clk edge with rst=1), with priority over everything:
  - state IDLE; hex_codes = all 31 (30'h3FFFFFFF); cmd_ready = 1; busy = 0.
  - Blink flag = 0; blink counter = 0; blink phase = on.
  - Reset mid-conversion aborts the conversion, with no display update.
- States:
  - IDLE: nothing shown yet.
  - SHOW: holding content.
  - CONV: 20 cycles.
  - LOAD: 1 cycle.
- cmd_ready = 1 in IDLE/SHOW and 0 in CONV/LOAD. busy = 1 in CONV/LOAD.
- A command is accepted on an edge where cmd_valid & cmd_ready. cmd_valid while not ready is ignored; nothing is queued.
- op 0/3 accepted:
  - Display register = all 31 at the accept edge.
  - Blink flag = cmd_blink.
  - Go to SHOW.
- op 1 accepted: display register loaded at the accept edge, left-justified from HEX5, unused digits 31. HEX5 downward:
  - "HI" = 19,1
  - "go" = 17,18
  - "Err" = 14,16,16
  - "SCOrE" = 5,12,0,16,14
  - Blink flag = cmd_blink; go to SHOW.
- op 2 accepted:
  - Capture the value, saturated to 999999 if cmd_value > 999999.
  - Capture cmd_lz_blank and cmd_blink.
  - Clear the 24-bit BCD register; go to CONV with iteration counter 0.
- Each CONV cycle performs one double-dabble step:
  - Each BCD nibble >= 5 gets +3.
  - Then shift {bcd, bin} left 1.
- After 20 steps go to LOAD.
- LOAD edge:
  - Display register = BCD nibbles, HEX5 = most significant.
  - If lz_blank, every zero digit left of the most significant nonzero digit becomes 31. Value 0 shows only HEX0 = 0.
  - Blink flag updated; go to SHOW.
- Number latency: accept edge E0; display updates at edge E21; cmd_ready high again in the cycle after E21.
- The previous display and its blink flag persist unchanged during CONV/LOAD.
- Blink:
  - Counter runs 0..BLINK_DIV-1 continuously; phase toggles on wrap.
  - Every accepted command resets the counter to 0 and the phase to on.
  - hex_codes = display register when blink flag = 0 or phase = on; otherwise all 31.
  - hex_codes is registered; the phase toggle is visible on the edge it occurs.

Test Plan:
- Reset: assert rst 2 cycles mid-operation -> hex_codes = 30'h3FFFFFFF, cmd_ready = 1, busy = 0 on the next edge.
- Number 123456, lz off -> cmd_ready = 0 for 21 cycles; then HEX5..HEX0 = 1,2,3,4,5,6 with busy = 0.
- Number 42 with lz on -> 31,31,31,31,4,2. Number 0 with lz on -> 31,31,31,31,31,0. Number 7 with lz off -> 0,0,0,0,0,7.
- Number 1000000 -> 9,9,9,9,9,9. Number 999999 -> identical result.
- Blink, with BLINK_DIV = 4:
  - Command msg 2 with blink -> HEX5..HEX3 = 14,16,16 for 4 cycles, then all 31 for 4, repeating.
  - A new command msg 0 without blink mid-off-phase -> 19,1 steady from the accept edge.
- Conversion overlap: while converting number 555, pulse cmd_valid with a msg 1 command -> ignored; the old display holds until LOAD shows 0,0,0,5,5,5, and the next msg 1 command is accepted normally.
